// File: rtl/fetch_sequencer.sv
// Program counter owner and fetch sequencer for a synchronous-read instruction memory.
// One fetch takes four cycles (IDLE, ISSUE, CAPTURE, DONE); redirects abort any in-flight fetch.
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned MEM_BYTES = 4096
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        fetch_req,
  input  logic        pc_load,
  input  logic [31:0] pc_load_value,
  output logic        mem_en,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata,
  output logic [31:0] ir,
  output logic [31:0] ir_pc,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        fetch_done,
  output logic        fetch_fault,
  output logic        busy,
  output logic [31:0] fetch_count
);

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] PC_MAX = XLEN'(MEM_BYTES - 4);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_CAPTURE = 2'd2,
    S_DONE    = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [XLEN-1:0]   ir_q, ir_d;
  logic [XLEN-1:0]   ir_pc_q, ir_pc_d;
  logic [XLEN-1:0]   mem_addr_q, mem_addr_d;
  logic [XLEN-1:0]   fetch_count_q, fetch_count_d;
  logic              mem_en_q, mem_en_d;
  logic              fetch_done_q, fetch_done_d;
  logic              fetch_fault_q, fetch_fault_d;
  logic              busy_q, busy_d;
  logic              pc_valid;

  // Next-state and registered-output logic; a redirect outranks everything else.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    ir_d          = ir_q;
    ir_pc_d       = ir_pc_q;
    mem_addr_d    = mem_addr_q;
    fetch_count_d = fetch_count_q;
    fetch_fault_d = fetch_fault_q;
    mem_en_d      = 1'b0;
    fetch_done_d  = 1'b0;
    pc_valid      = (pc_q[1:0] == 2'b00) && (pc_q <= PC_MAX);

    if (pc_load) begin
      pc_d          = pc_load_value;
      state_d       = S_IDLE;
      fetch_fault_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (fetch_req) begin
            if (pc_valid) begin
              state_d    = S_ISSUE;
              mem_en_d   = 1'b1;
              mem_addr_d = pc_q;
            end else begin
              fetch_fault_d = 1'b1;
            end
          end
        end
        S_ISSUE: begin
          state_d = S_CAPTURE;
        end
        S_CAPTURE: begin
          ir_d          = mem_rdata;
          ir_pc_d       = pc_q;
          pc_d          = pc_q + XLEN'(4);
          fetch_count_d = fetch_count_q + XLEN'(1);
          fetch_done_d  = 1'b1;
          state_d       = S_DONE;
        end
        S_DONE: begin
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= S_IDLE;
      pc_q          <= RESET_PC;
      ir_q          <= '0;
      ir_pc_q       <= '0;
      mem_addr_q    <= RESET_PC;
      fetch_count_q <= '0;
      mem_en_q      <= 1'b0;
      fetch_done_q  <= 1'b0;
      fetch_fault_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      ir_q          <= ir_d;
      ir_pc_q       <= ir_pc_d;
      mem_addr_q    <= mem_addr_d;
      fetch_count_q <= fetch_count_d;
      mem_en_q      <= mem_en_d;
      fetch_done_q  <= fetch_done_d;
      fetch_fault_q <= fetch_fault_d;
      busy_q        <= busy_d;
    end
  end

  assign mem_en      = mem_en_q;
  assign mem_addr    = mem_addr_q;
  assign ir          = ir_q;
  assign ir_pc       = ir_pc_q;
  assign pc          = pc_q;
  assign pc_plus4    = ir_pc_q + XLEN'(4);
  assign fetch_done  = fetch_done_q;
  assign fetch_fault = fetch_fault_q;
  assign busy        = busy_q;
  assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: behavioural instruction memory plus a
// queue of expected fetch results popped when fetch_done pulses.
module tb_fetch_sequencer;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        fetch_req = 1'b0;
  logic        pc_load = 1'b0;
  logic [31:0] pc_load_value = '0;
  logic        mem_en;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata = '0;
  logic [31:0] ir, ir_pc, pc, pc_plus4, fetch_count;
  logic        fetch_done, fetch_fault, busy;

  fetch_sequencer #(.RESET_PC(32'h0), .MEM_BYTES(4096)) dut (
    .clock(clock), .reset(reset), .fetch_req(fetch_req), .pc_load(pc_load),
    .pc_load_value(pc_load_value), .mem_en(mem_en), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .ir(ir), .ir_pc(ir_pc), .pc(pc), .pc_plus4(pc_plus4),
    .fetch_done(fetch_done), .fetch_fault(fetch_fault), .busy(busy),
    .fetch_count(fetch_count)
  );

  always #5 clock = ~clock;

  logic [31:0] mem [1024];
  always @(posedge clock) if (mem_en) mem_rdata <= mem[mem_addr[11:2]];

  typedef struct {
    logic [31:0] ir;
    logic [31:0] ir_pc;
    logic [31:0] pc;
    logic [31:0] cnt;
  } exp_t;
  exp_t sb[$];

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] m_pc, m_ir, m_ir_pc, m_cnt;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic load_pc(input logic [31:0] v);
    pc_load = 1'b1;
    pc_load_value = v;
    tick();
    pc_load = 1'b0;
    m_pc = v;
    n_vec++;
    if (pc !== v) begin n_err++; $display("FAIL load_pc: pc=%h want %h", pc, v); end
    n_vec++;
    if (fetch_fault !== 1'b0) begin n_err++; $display("FAIL load_clears_fault: fault=%b want 0", fetch_fault); end
  endtask

  task automatic do_fetch();
    exp_t e, got;
    bit seen;
    e.ir = mem[m_pc[11:2]];
    e.ir_pc = m_pc;
    e.pc = m_pc + 32'd4;
    e.cnt = m_cnt + 32'd1;
    sb.push_back(e);
    fetch_req = 1'b1;
    tick();
    fetch_req = 1'b0;
    n_vec++;
    if (mem_en !== 1'b1 || mem_addr !== m_pc) begin
      n_err++; $display("FAIL issue: mem_en=%b mem_addr=%h want 1 %h", mem_en, mem_addr, m_pc);
    end
    tick();
    n_vec++;
    if (mem_en !== 1'b0 || fetch_done !== 1'b0) begin
      n_err++; $display("FAIL capture_cycle: mem_en=%b done=%b want 0 0", mem_en, fetch_done);
    end
    seen = 0;
    for (int i = 0; i < 4 && !seen; i++) begin
      tick();
      if (fetch_done === 1'b1) seen = 1;
    end
    n_vec++;
    if (!seen) begin
      n_err++; $display("FAIL fetch_timeout: no fetch_done within bound");
    end else if (sb.size() > 0) begin
      got.ir = ir; got.ir_pc = ir_pc; got.pc = pc; got.cnt = fetch_count;
      e = sb.pop_front();
      if (got.ir !== e.ir || got.ir_pc !== e.ir_pc || got.pc !== e.pc || got.cnt !== e.cnt ||
          pc_plus4 !== e.ir_pc + 32'd4 || busy !== 1'b1) begin
        n_err++;
        $display("FAIL fetch_result: ir=%h ir_pc=%h pc=%h cnt=%0d p4=%h busy=%b want %h %h %h %0d %h 1",
                 got.ir, got.ir_pc, got.pc, got.cnt, pc_plus4, busy, e.ir, e.ir_pc, e.pc, e.cnt, e.ir_pc + 32'd4);
      end
      m_pc = e.pc; m_cnt = e.cnt; m_ir = e.ir; m_ir_pc = e.ir_pc;
    end
    tick();
    n_vec++;
    if (fetch_done !== 1'b0 || busy !== 1'b0) begin
      n_err++; $display("FAIL done_pulse: done=%b busy=%b want 0 0", fetch_done, busy);
    end
  endtask

  task automatic try_fault();
    fetch_req = 1'b1;
    tick();
    fetch_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_vec++;
      if (mem_en !== 1'b0 || busy !== 1'b0) begin
        n_err++; $display("FAIL fault_no_access: mem_en=%b busy=%b want 0 0", mem_en, busy);
      end
      tick();
    end
    n_vec++;
    if (fetch_fault !== 1'b1) begin n_err++; $display("FAIL fault_flag: fault=%b want 1", fetch_fault); end
  endtask

  task automatic check_reset_state(input string tag);
    n_vec++;
    if (pc !== 32'h0 || ir !== 32'h0 || ir_pc !== 32'h0 || fetch_done !== 1'b0 ||
        fetch_fault !== 1'b0 || mem_en !== 1'b0 || mem_addr !== 32'h0 ||
        fetch_count !== 32'h0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL %s: pc=%h ir=%h ir_pc=%h done=%b fault=%b en=%b addr=%h cnt=%0d busy=%b want all zero",
               tag, pc, ir, ir_pc, fetch_done, fetch_fault, mem_en, mem_addr, fetch_count, busy);
    end
    m_pc = 0; m_ir = 0; m_ir_pc = 0; m_cnt = 0;
    sb.delete();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    check_reset_state("reset");
  endtask

  task automatic test_basic();
    do_fetch();
    do_fetch();
  endtask

  task automatic test_load();
    load_pc(32'h30);
    do_fetch();
  endtask

  task automatic test_flush();
    load_pc(32'h10);
    fetch_req = 1'b1;
    tick();
    fetch_req = 1'b0;
    tick();
    pc_load = 1'b1;
    pc_load_value = 32'h04;
    tick();
    pc_load = 1'b0;
    m_pc = 32'h04;
    for (int i = 0; i < 2; i++) begin
      n_vec++;
      if (fetch_done !== 1'b0 || ir !== m_ir || ir_pc !== m_ir_pc || pc !== 32'h04 ||
          fetch_count !== m_cnt || busy !== 1'b0 || mem_en !== 1'b0) begin
        n_err++;
        $display("FAIL flush: done=%b ir=%h ir_pc=%h pc=%h cnt=%0d busy=%b en=%b want 0 %h %h 4 %0d 0 0",
                 fetch_done, ir, ir_pc, pc, fetch_count, busy, mem_en, m_ir, m_ir_pc, m_cnt);
      end
      tick();
    end
    do_fetch();
  endtask

  task automatic test_faults();
    load_pc(32'h06);
    try_fault();
    load_pc(32'h1000);
    try_fault();
    load_pc(32'h0);
  endtask

  task automatic test_boundary();
    load_pc(32'hFFC);
    do_fetch();
    try_fault();
  endtask

  task automatic test_reset_midfetch();
    load_pc(32'h08);
    fetch_req = 1'b1;
    tick();
    fetch_req = 1'b0;
    n_vec++;
    if (mem_en !== 1'b1 || busy !== 1'b1) begin
      n_err++; $display("FAIL midfetch_issue: en=%b busy=%b want 1 1", mem_en, busy);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_reset_state("reset_midfetch");
    tick();
    n_vec++;
    if (fetch_done !== 1'b0 || busy !== 1'b0) begin
      n_err++; $display("FAIL reset_no_resume: done=%b busy=%b want 0 0", fetch_done, busy);
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'hC0DE_0000 | 32'(i);
    mem[0] = 32'h0012_3000;
    mem[1] = 32'h0491_8000;
    test_reset();
    test_basic();
    test_load();
    test_flush();
    test_faults();
    test_boundary();
    test_reset_midfetch();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
